// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, bus constants
// and the byte width.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    PTR,
    ACK_PTR,
    WDATA,
    ACK_WDATA,
    RDATA,
    MACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_target_mem_line_filter.sv
// Line conditioning for one bus wire: 2-flop synchroniser, stability filter
// and registered rise/fall strobes aligned with the filtered level change.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   line_i        raw pin value
//   level_o       filtered level (resets to 1)
//   rise_o        one-cycle pulse when level_o goes 0->1
//   fall_o        one-cycle pulse when level_o goes 1->0
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Synchroniser; idle bus level is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

  // Count consecutive samples that disagree with the filtered level; adopt the
  // new level on the FILTER_LEN-th one. Any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      rise_d  = sync_q[1];
      fall_d  = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with an internal byte memory: EEPROM-style pointer write, burst
// write and burst read with wrap-around.
// Ports:
//   pclk, preset             oversampling clock, asynchronous active-high reset
//   scl_i, sda_i             raw bus pins
//   sda_oe_o                 1 = pull SDA low
//   data_slave_read_o        last byte written by the master
//   data_slave_read_valid_o  pulse when data_slave_read_o updates
//   start_o, stop_o          pulses on START/repeated START and STOP
//   addr_match_o             high from address ACK until next START/STOP
//   dbg_addr_i, dbg_data_o   combinational debug read port into the memory
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR   = 7'h50,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe_o,
  output logic [BYTE_W-1:0]        data_slave_read_o,
  output logic                     data_slave_read_valid_o,
  output logic                     start_o,
  output logic                     stop_o,
  output logic                     addr_match_o,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
  output logic [BYTE_W-1:0]        dbg_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i   (pclk),
    .rst_i   (preset),
    .line_i  (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i   (pclk),
    .rst_i   (preset),
    .line_i  (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  i2c_state_e          state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                rw_q, rw_d;
  logic                sda_oe_q, sda_oe_d;
  logic [BYTE_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                match_q, match_d;
  logic [BYTE_W-1:0]   mem_q [DEPTH];

  logic                start_det, stop_det, last_bit;
  logic [BYTE_W-1:0]   byte_in;
  logic [PTR_W-1:0]    ptr_inc;

  // SDA falling/rising is only a bus condition while the filtered SCL is high.
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign byte_in   = {shift_q[BYTE_W-2:0], sda_lvl};
  assign ptr_inc   = ptr_q + PTR_W'(1);

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; bus conditions override everything, bits advance on scl_rise.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else if (scl_rise) begin
      case (state_q)
        ADDR:      if (last_bit) state_d = (byte_in[7:1] == SLV_ADDR) ? ACK_ADDR : IDLE;
        ACK_ADDR:  state_d = rw_q ? RDATA : PTR;
        PTR:       if (last_bit) state_d = ACK_PTR;
        ACK_PTR:   state_d = WDATA;
        WDATA:     if (last_bit) state_d = ACK_WDATA;
        ACK_WDATA: state_d = WDATA;
        RDATA:     if (last_bit) state_d = MACK;
        MACK:      state_d = (sda_lvl == I2C_NACK) ? IDLE : RDATA;
        default:   state_d = state_q;
      endcase
    end
  end

  // Output and datapath next values. SDA drive only moves on scl_fall so it is
  // stable for the whole SCL-high phase the master samples in.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    wr_addr_d  = wr_addr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    match_d    = match_q;
    if (start_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      start_d   = 1'b1;
      match_d   = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      stop_d    = 1'b1;
      match_d   = 1'b0;
    end else begin
      if (scl_fall) begin
        case (state_q)
          ACK_ADDR, ACK_PTR, ACK_WDATA: sda_oe_d = 1'b1;
          RDATA:                        sda_oe_d = ~shift_q[BYTE_W-1];
          default:                      sda_oe_d = 1'b0;
        endcase
      end
      if (scl_rise) begin
        case (state_q)
          ADDR: begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              rw_d    = sda_lvl;
              match_d = (byte_in[7:1] == SLV_ADDR);
            end
          end
          ACK_ADDR: begin
            bit_cnt_d = '0;
            if (rw_q) shift_d = mem_q[ptr_q];
          end
          PTR: begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) ptr_d = byte_in[PTR_W-1:0];
          end
          ACK_PTR, ACK_WDATA: bit_cnt_d = '0;
          WDATA: begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              rd_data_d  = byte_in;
              rd_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              ptr_d      = ptr_inc;
            end
          end
          RDATA: begin
            shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          MACK: begin
            bit_cnt_d = '0;
            if (sda_lvl == I2C_ACK) begin
              ptr_d   = ptr_inc;
              shift_d = mem_q[ptr_inc];
            end
          end
          default: bit_cnt_d = bit_cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      wr_addr_q  <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      wr_addr_q  <= wr_addr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      match_q    <= match_d;
    end
  end

  // Memory commit trails the valid pulse by one cycle, so dbg_data_o still
  // shows the old byte while data_slave_read_valid_o is high.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (rd_valid_q) begin
      mem_q[wr_addr_q] <= rd_data_q;
    end
  end

  assign sda_oe_o                = sda_oe_q;
  assign data_slave_read_o       = rd_data_q;
  assign data_slave_read_valid_o = rd_valid_q;
  assign start_o                 = start_q;
  assign stop_o                  = stop_q;
  assign addr_match_o            = match_q;
  assign dbg_data_o              = mem_q[dbg_addr_i];

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-banged open-drain master, transaction-level
// memory/pointer model, directed scenarios followed by randomized traffic.
module tb_i2c_target_mem;

  localparam int H = 15;  // SCL high phase and main low phase, pclk cycles
  localparam int Q = 8;   // hold after SCL fall before SDA moves

  logic       pclk = 1'b0;
  logic       preset;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rd_data;
  logic       rd_valid, start_p, stop_p, match;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 pclk = ~pclk;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_mem dut (
    .pclk                    (pclk),
    .preset                  (preset),
    .scl_i                   (m_scl),
    .sda_i                   (sda_bus),
    .sda_oe_o                (sda_oe),
    .data_slave_read_o       (rd_data),
    .data_slave_read_valid_o (rd_valid),
    .start_o                 (start_p),
    .stop_o                  (stop_p),
    .addr_match_o            (match),
    .dbg_addr_i              (dbg_addr),
    .dbg_data_o              (dbg_data)
  );

  int total = 0;
  int bad   = 0;

  // Monitor state, written only by the monitor process.
  int         start_cnt = 0, stop_cnt = 0, oe_cnt = 0, match_cnt = 0;
  logic [7:0] vq[$], oldq[$], newq[$];
  logic       vld_d = 1'b0;

  always @(negedge pclk) begin
    if (start_p) start_cnt++;
    if (stop_p) stop_cnt++;
    if (sda_oe) oe_cnt++;
    if (match) match_cnt++;
    if (vld_d) newq.push_back(dbg_data);
    vld_d = rd_valid;
    if (rd_valid) begin
      vq.push_back(rd_data);
      oldq.push_back(dbg_data);
    end
  end

  // Reference model: byte memory and pointer at transaction level.
  logic [7:0] mem_m [16];
  int         ptr_m;
  int         vidx;
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_start();
    m_sda = 1'b1; cyc(Q);
    m_scl = 1'b1; cyc(H);
    m_sda = 1'b0; cyc(H);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b1; cyc(H);
    m_sda = 1'b1; cyc(H);
  endtask

  // One SCL period; g=1 glitches SCL low, g=2 glitches SDA low (on 1 bits),
  // each for 2 cycles while SCL is high.
  task automatic bit_xfer(input logic b, input int g, output logic rb, output logic oe);
    m_sda = b; cyc(H);
    m_scl = 1'b1; cyc(6);
    if (g == 1) begin
      m_scl = 1'b0; cyc(2); m_scl = 1'b1;
    end else if (g == 2 && b) begin
      m_sda = 1'b0; cyc(2); m_sda = 1'b1;
    end else begin
      cyc(2);
    end
    cyc(3);
    rb = sda_bus;
    oe = sda_oe;
    cyc(H - 11);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int g, output logic ack);
    logic rb, oe;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], g, rb, oe);
    bit_xfer(1'b1, 0, rb, oe);
    ack = ~rb;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d, output logic oe9);
    logic rb, oe;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 0, rb, oe);
      d[i] = rb;
    end
    bit_xfer(nack, 0, rb, oe9);
  endtask

  task automatic mem_cmp();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk("mem", dbg_data, mem_m[i]);
    end
  endtask

  task automatic txn_write(input logic [7:0] p, input int n, input int g);
    logic       ack;
    logic [7:0] old;
    do_start();
    wr_byte(8'hA0, 0, ack);
    chk("w_addr_ack", ack, 1'b1);
    chk("w_match", match, 1'b1);
    wr_byte(p, 0, ack);
    chk("w_ptr_ack", ack, 1'b1);
    ptr_m = int'(p) % 16;
    for (int i = 0; i < n; i++) begin
      dbg_addr = 4'(ptr_m);
      old = mem_m[ptr_m];
      wr_byte(wbuf[i], g, ack);
      chk("w_data_ack", ack, 1'b1);
      chk("w_valid_cnt", vq.size(), vidx + 1);
      if (vq.size() > vidx && newq.size() > vidx) begin
        chk("w_valid_data", vq[vidx], wbuf[i]);
        chk("w_dbg_old", oldq[vidx], old);
        chk("w_dbg_new", newq[vidx], wbuf[i]);
      end
      vidx = vq.size();
      mem_m[ptr_m] = wbuf[i];
      ptr_m = (ptr_m + 1) % 16;
    end
    do_stop();
    chk("w_match_clr", match, 1'b0);
    chk("w_oe_after", sda_oe, 1'b0);
  endtask

  task automatic txn_read(input logic use_ptr, input logic [7:0] p, input int n);
    logic       ack, oe9;
    logic [7:0] d;
    do_start();
    if (use_ptr) begin
      wr_byte(8'hA0, 0, ack);
      chk("r_waddr_ack", ack, 1'b1);
      wr_byte(p, 0, ack);
      chk("r_ptr_ack", ack, 1'b1);
      ptr_m = int'(p) % 16;
      do_start();
    end
    wr_byte(8'hA1, 0, ack);
    chk("r_addr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d, oe9);
      chk("r_data", d, mem_m[ptr_m]);
      chk("r_mack_oe", oe9, 1'b0);
      rbuf[i] = d;
      if (i != n - 1) ptr_m = (ptr_m + 1) % 16;
    end
    do_stop();
    chk("r_oe_after", sda_oe, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         s0, p0, m0, o0, v0;
    logic       ack;
    logic [7:0] pr;
    int         n;

    preset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; dbg_addr = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    ptr_m = 0; vidx = 0;
    cyc(5);
    preset = 1'b0;
    cyc(5);

    // Reset state
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_start", start_p, 1'b0);
    chk("rst_stop", stop_p, 1'b0);
    chk("rst_match", match, 1'b0);
    mem_cmp();

    // Pointer write: ptr 3, data 11 22
    s0 = start_cnt; p0 = stop_cnt;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    txn_write(8'h03, 2, 0);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_stops", stop_cnt - p0, 1);
    dbg_addr = 4'd3; #1; chk("t1_mem3", dbg_data, 8'h11);
    dbg_addr = 4'd4; #1; chk("t1_mem4", dbg_data, 8'h22);

    // Wrap-around: seed mem[1], write at 0x0F, then current-address read at 1
    wbuf[0] = 8'h5C;
    txn_write(8'h01, 1, 0);
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    txn_write(8'h0F, 2, 0);
    dbg_addr = 4'd15; #1; chk("wrap_mem15", dbg_data, 8'hAA);
    dbg_addr = 4'd0;  #1; chk("wrap_mem0", dbg_data, 8'hBB);
    txn_read(1'b0, 8'h00, 1);
    chk("wrap_ptr1_read", rbuf[0], 8'h5C);

    // Repeated-START read of two bytes from 3
    s0 = start_cnt;
    txn_read(1'b1, 8'h03, 2);
    chk("sr_rd0", rbuf[0], 8'h11);
    chk("sr_rd1", rbuf[1], 8'h22);
    chk("sr_starts", start_cnt - s0, 2);

    // Address mismatch
    o0 = oe_cnt; m0 = match_cnt; v0 = vq.size();
    do_start();
    wr_byte(8'hA2, 0, ack);
    chk("mm_nack", ack, 1'b0);
    for (int i = 0; i < 3; i++) wr_byte(8'($urandom), 0, ack);
    do_stop();
    chk("mm_oe", oe_cnt - o0, 0);
    chk("mm_match", match_cnt - m0, 0);
    chk("mm_valid", vq.size() - v0, 0);
    chk("mm_match_now", match, 1'b0);
    mem_cmp();

    // Glitch rejection on SCL, then on SDA
    s0 = start_cnt; p0 = stop_cnt;
    wbuf[0] = 8'h96; wbuf[1] = 8'h69;
    txn_write(8'h08, 2, 1);
    wbuf[0] = 8'hE7; wbuf[1] = 8'h3C;
    txn_write(8'h0A, 2, 2);
    chk("gl_starts", start_cnt - s0, 2);
    chk("gl_stops", stop_cnt - p0, 2);
    mem_cmp();

    // Reset in the middle of a read while the target drives SDA (mem[3]=0x11)
    do_start();
    wr_byte(8'hA0, 0, ack);
    wr_byte(8'h03, 0, ack);
    do_start();
    wr_byte(8'hA1, 0, ack);
    for (int k = 0; k < 40 && sda_oe !== 1'b1; k++) cyc(1);
    chk("mr_oe_before", sda_oe, 1'b1);
    preset = 1'b1;
    #1;
    chk("mr_oe_async", sda_oe, 1'b0);
    m_sda = 1'b1; m_scl = 1'b1;
    cyc(4);
    preset = 1'b0;
    cyc(10);
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    ptr_m = 0;
    vidx = vq.size();
    mem_cmp();
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    txn_write(8'h05, 2, 0);
    txn_read(1'b1, 8'h05, 2);

    // Randomized traffic against the model
    for (int it = 0; it < 6; it++) begin
      pr = 8'($urandom);
      n  = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      txn_write(pr, n, 0);
      n = int'($urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) txn_read(1'b0, 8'h00, n);
      else txn_read(1'b1, 8'($urandom), n);
    end
    mem_cmp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
